// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one memory between program-fetch and data ports
module mem_bus_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CS_P,
    input  logic [31:0] ADDR_Prog,
    output logic [31:0] Prog_BUS_READ,
    output logic        RDY_P,
    input  logic        CS,
    input  logic        WR_RD,
    input  logic [31:0] ADDR,
    input  logic [31:0] Data_BUS_WRITE,
    output logic [31:0] Data_BUS_READ,
    output logic        RDY_D,
    output logic        MEM_CS,
    output logic        MEM_WR,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA
);

    // Counter value on the final access cycle; counter starts at 0 on the grant edge.
    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic       owner_prog;   // 1 = current access belongs to the program port
    logic       last_prog;    // round-robin flag: 1 = program port was served last
    logic       grant;
    logic       grant_prog;
    logic       finish;

    // State register; reset lands in IDLE immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the grant/finish strobes that steer the datapath.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_prog = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (CS_P || CS) begin
                    grant      = 1'b1;
                    // On a tie the port not served last wins.
                    grant_prog = CS_P && (!CS || !last_prog);
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == LAST_CNT) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Access datapath: latch operands at grant, hold memory outputs stable, capture read data and pulse RDY at completion.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt           <= 4'd0;
            owner_prog    <= 1'b0;
            last_prog     <= 1'b1;
            MEM_CS        <= 1'b0;
            MEM_WR        <= 1'b0;
            MEM_ADDR      <= 32'd0;
            MEM_WDATA     <= 32'd0;
            RDY_P         <= 1'b0;
            RDY_D         <= 1'b0;
            Prog_BUS_READ <= 32'd0;
            Data_BUS_READ <= 32'd0;
        end else begin
            RDY_P <= 1'b0;
            RDY_D <= 1'b0;
            if (grant) begin
                owner_prog <= grant_prog;
                cnt        <= 4'd0;
                MEM_CS     <= 1'b1;
                MEM_ADDR   <= grant_prog ? ADDR_Prog : ADDR;
                MEM_WDATA  <= grant_prog ? 32'd0 : Data_BUS_WRITE;
                MEM_WR     <= grant_prog ? 1'b0 : WR_RD;
            end else if (finish) begin
                cnt       <= 4'd0;
                last_prog <= owner_prog;
                MEM_CS    <= 1'b0;
                MEM_WR    <= 1'b0;
                MEM_ADDR  <= 32'd0;
                MEM_WDATA <= 32'd0;
                if (owner_prog) begin
                    RDY_P         <= 1'b1;
                    Prog_BUS_READ <= MEM_RDATA;
                end else begin
                    RDY_D <= 1'b1;
                    // MEM_WR still carries the latched direction on the last access cycle.
                    if (!MEM_WR) begin
                        Data_BUS_READ <= MEM_RDATA;
                    end
                end
            end else if (state == ACCESS) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        CLK;
    logic        RST;
    logic        CS_P;
    logic [31:0] ADDR_Prog;
    logic [31:0] Prog_BUS_READ;
    logic        RDY_P;
    logic        CS;
    logic        WR_RD;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic [31:0] Data_BUS_READ;
    logic        RDY_D;
    logic        MEM_CS;
    logic        MEM_WR;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    mem_bus_arbiter #(.MEM_LAT(2)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .CS_P           (CS_P),
        .ADDR_Prog      (ADDR_Prog),
        .Prog_BUS_READ  (Prog_BUS_READ),
        .RDY_P          (RDY_P),
        .CS             (CS),
        .WR_RD          (WR_RD),
        .ADDR           (ADDR),
        .Data_BUS_WRITE (Data_BUS_WRITE),
        .Data_BUS_READ  (Data_BUS_READ),
        .RDY_D          (RDY_D),
        .MEM_CS         (MEM_CS),
        .MEM_WR         (MEM_WR),
        .MEM_ADDR       (MEM_ADDR),
        .MEM_WDATA      (MEM_WDATA),
        .MEM_RDATA      (MEM_RDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cycle++;
    endtask

    initial begin
        int prev_rdy;
        logic exp_prog;
        logic seen;

        RST = 1'b0; CS_P = 1'b0; CS = 1'b0; WR_RD = 1'b0;
        ADDR_Prog = 32'd0; ADDR = 32'd0; Data_BUS_WRITE = 32'd0; MEM_RDATA = 32'd0;
        step(); step();
        check_eq("rst_mem_cs",   {31'd0, MEM_CS}, 32'd0);
        check_eq("rst_mem_wr",   {31'd0, MEM_WR}, 32'd0);
        check_eq("rst_mem_addr", MEM_ADDR, 32'd0);
        check_eq("rst_rdy",      {30'd0, RDY_P, RDY_D}, 32'd0);
        check_eq("rst_prog_rd",  Prog_BUS_READ, 32'd0);
        check_eq("rst_data_rd",  Data_BUS_READ, 32'd0);
        RST = 1'b1;
        step();

        // Program fetch: request raised now, grant on the next edge, RDY_P two edges later.
        CS_P = 1'b1; ADDR_Prog = 32'h0040_0000; MEM_RDATA = 32'h2008_000A;
        step();
        check_eq("p_acc1_cs",   {31'd0, MEM_CS}, 32'd1);
        check_eq("p_acc1_addr", MEM_ADDR, 32'h0040_0000);
        check_eq("p_acc1_wr",   {31'd0, MEM_WR}, 32'd0);
        check_eq("p_acc1_rdy",  {31'd0, RDY_P}, 32'd0);
        step();
        check_eq("p_acc2_cs",   {31'd0, MEM_CS}, 32'd1);
        check_eq("p_acc2_addr", MEM_ADDR, 32'h0040_0000);
        step();
        check_eq("p_done_cs",   {31'd0, MEM_CS}, 32'd0);
        check_eq("p_done_rdyp", {31'd0, RDY_P}, 32'd1);
        check_eq("p_done_rdyd", {31'd0, RDY_D}, 32'd0);
        check_eq("p_done_rd",   Prog_BUS_READ, 32'h2008_000A);
        CS_P = 1'b0;
        step();
        check_eq("p_idle_rdyp", {31'd0, RDY_P}, 32'd0);
        check_eq("p_idle_cs",   {31'd0, MEM_CS}, 32'd0);

        // Data write: MEM_WR high for both access cycles, read register untouched.
        CS = 1'b1; WR_RD = 1'b1; ADDR = 32'h1001_0004; Data_BUS_WRITE = 32'hDEAD_BEEF;
        MEM_RDATA = 32'h55AA_55AA;
        step();
        check_eq("w_acc1_wr",    {31'd0, MEM_WR}, 32'd1);
        check_eq("w_acc1_wdata", MEM_WDATA, 32'hDEAD_BEEF);
        check_eq("w_acc1_addr",  MEM_ADDR, 32'h1001_0004);
        step();
        check_eq("w_acc2_wr",    {31'd0, MEM_WR}, 32'd1);
        check_eq("w_acc2_wdata", MEM_WDATA, 32'hDEAD_BEEF);
        step();
        check_eq("w_done_wr",    {31'd0, MEM_WR}, 32'd0);
        check_eq("w_done_rdy",   {30'd0, RDY_P, RDY_D}, 32'd1);
        check_eq("w_done_rd",    Data_BUS_READ, 32'd0);
        CS = 1'b0; WR_RD = 1'b0;
        step();
        check_eq("w_idle_wr",    {31'd0, MEM_WR}, 32'd0);

        // Data read aborted by reset in its second access cycle, then restarted.
        CS = 1'b1; WR_RD = 1'b0; ADDR = 32'h1001_0008; MEM_RDATA = 32'h1234_5678;
        step();
        step();
        check_eq("ab_acc2_cs", {31'd0, MEM_CS}, 32'd1);
        #2 RST = 1'b0;
        #1;
        check_eq("ab_async_cs",   {31'd0, MEM_CS}, 32'd0);
        check_eq("ab_async_addr", MEM_ADDR, 32'd0);
        check_eq("ab_async_prog", Prog_BUS_READ, 32'd0);
        check_eq("ab_async_rdy",  {30'd0, RDY_P, RDY_D}, 32'd0);
        step();
        check_eq("ab_rst_rdy",    {30'd0, RDY_P, RDY_D}, 32'd0);
        RST = 1'b1;
        step();
        check_eq("ab_re_cs",   {31'd0, MEM_CS}, 32'd1);
        check_eq("ab_re_addr", MEM_ADDR, 32'h1001_0008);
        step();
        check_eq("ab_re_rdy1", {31'd0, RDY_D}, 32'd0);
        step();
        check_eq("ab_re_rdyd", {31'd0, RDY_D}, 32'd1);
        check_eq("ab_re_rd",   Data_BUS_READ, 32'h1234_5678);
        CS = 1'b0;
        step();

        // Fresh reset in IDLE so the first tie goes to the data port.
        #2 RST = 1'b0;
        #1;
        check_eq("rst2_data_rd", Data_BUS_READ, 32'd0);
        step();
        RST = 1'b1;
        step();

        // Round robin with both requests held: data, program, data, program, 4 cycles apart.
        CS = 1'b1; CS_P = 1'b1; WR_RD = 1'b0;
        ADDR = 32'h1001_0100; ADDR_Prog = 32'h0040_0100; MEM_RDATA = 32'h0BAD_F00D;
        prev_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            exp_prog = (i % 2) == 1;
            seen = 1'b0;
            for (int k = 0; k < 10; k++) begin
                step();
                if (RDY_P && RDY_D) check_eq("rr_both_rdy", 32'd1, 32'd0);
                if (RDY_P || RDY_D) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) begin
                check_eq("rr_timeout", 32'd0, 32'd1);
            end else begin
                check_eq("rr_owner", {31'd0, RDY_P}, {31'd0, exp_prog});
                if (i > 0) check_eq("rr_gap", 32'(cycle - prev_rdy), 32'd4);
                prev_rdy = cycle;
            end
        end
        CS = 1'b0; CS_P = 1'b0;
        step();
        step();

        // Program request dropped in the first access cycle still completes.
        CS_P = 1'b1; ADDR_Prog = 32'h0040_0010; MEM_RDATA = 32'hCAFE_F00D;
        step();
        CS_P = 1'b0;
        check_eq("drop_acc1_cs", {31'd0, MEM_CS}, 32'd1);
        step();
        check_eq("drop_acc2_cs", {31'd0, MEM_CS}, 32'd1);
        step();
        check_eq("drop_rdyp",    {31'd0, RDY_P}, 32'd1);
        check_eq("drop_prog_rd", Prog_BUS_READ, 32'hCAFE_F00D);
        check_eq("drop_done_cs", {31'd0, MEM_CS}, 32'd0);
        step();
        check_eq("drop_idle",    {30'd0, RDY_P, MEM_CS}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
